// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: round-robin sharing of the sd_card single-sector read port among four requesters.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module sd_read_arbiter #(
  parameter int          HOLD    = 32,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [127:0] req_sec,
  output logic [3:0]   grant,
  output logic         busy,
  output logic [3:0]   done,
  output logic [3:0]   err,
  output logic [7:0]   rd_data,
  output logic [3:0]   rd_valid,
  output logic [8:0]   rd_idx,
  input  logic         sd_init,
  output logic [31:0]  sd_sec,
  output logic         sd_read,
  input  logic [7:0]   sd_data,
  input  logic         sd_valid,
  input  logic         sd_read_done
);

  localparam int HW = $clog2(HOLD + 1);

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_XFER      = 3'd3,
    S_FINISH    = 3'd4,
    S_RECOVER   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      init_sync_q, valid_sync_q, rdone_sync_q;
  logic            valid_prev_q;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0]      grant_q, grant_d;
  logic [31:0]     sec_q, sec_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [23:0]     tmo_q, tmo_d;
  logic [9:0]      nidx_q, nidx_d;
  logic [8:0]      rd_idx_q, rd_idx_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [3:0]      rd_valid_q, rd_valid_d;
  logic [3:0]      done_q, done_d;
  logic [3:0]      err_q, err_d;

  logic            init_s, rdone_s, byte_ev, active, accept, tmo_hit, found;
  logic [1:0]      win, idx;

  // sd_card status lines come from the SD_clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_sync_q  <= '0;
      valid_sync_q <= '0;
      rdone_sync_q <= '0;
      valid_prev_q <= 1'b0;
    end else begin
      init_sync_q  <= {init_sync_q[0], sd_init};
      valid_sync_q <= {valid_sync_q[0], sd_valid};
      rdone_sync_q <= {rdone_sync_q[0], sd_read_done};
      valid_prev_q <= valid_sync_q[1];
    end
  end

  assign init_s  = init_sync_q[1];
  assign rdone_s = rdone_sync_q[1];
  assign byte_ev = valid_sync_q[1] & ~valid_prev_q;
  assign active  = (state_q == S_ISSUE) || (state_q == S_XFER) || (state_q == S_FINISH);
  assign tmo_hit = active && (tmo_q == TIMEOUT - 24'd1);
  // nidx_q[9] marks a full sector, so rd_idx can never wrap back to 0.
  assign accept  = byte_ev && !nidx_q[9] && ((state_q == S_ISSUE) || (state_q == S_XFER));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    sec_d      = sec_q;
    hold_d     = hold_q;
    tmo_d      = tmo_q;
    nidx_d     = nidx_q;
    rd_idx_d   = rd_idx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    done_d     = '0;
    err_d      = '0;
    found      = 1'b0;
    win        = 2'd0;
    idx        = 2'd0;

    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    if (active && (tmo_q != 24'hFFFFFF)) tmo_d = tmo_q + 24'd1;

    if (accept) begin
      rd_valid_d = grant_q;
      rd_data_d  = sd_data;
      rd_idx_d   = nidx_q[8:0];
      nidx_d     = nidx_q + 10'd1;
    end

    case (state_q)
      S_WAIT_INIT: if (init_s) state_d = S_IDLE;
      S_IDLE: begin
        if (!init_s) begin
          state_d = S_WAIT_INIT;
        end else if (found) begin
          grant_d  = 4'b0001 << win;
          sec_d    = req_sec[{win, 5'd0} +: 32];
          ptr_d    = win + 2'd1;
          rd_idx_d = '0;
          nidx_d   = '0;
          tmo_d    = '0;
          hold_d   = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HW'(HOLD - 1)) begin
          hold_d  = '0;
          state_d = nidx_d[9] ? S_FINISH : S_XFER;
        end
      end
      S_XFER: if (nidx_d[9]) state_d = S_FINISH;
      S_FINISH: begin
        if (rdone_s) begin
          done_d  = grant_q;
          grant_d = '0;
          hold_d  = '0;
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HW'(HOLD - 1)) begin
          hold_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_WAIT_INIT;
    endcase

    // A completion seen in the same cycle as the timeout wins.
    if (tmo_hit && !((state_q == S_FINISH) && rdone_s)) begin
      err_d   = grant_q;
      grant_d = '0;
      hold_d  = '0;
      state_d = S_RECOVER;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT_INIT;
      ptr_q      <= '0;
      grant_q    <= '0;
      sec_q      <= '0;
      hold_q     <= '0;
      tmo_q      <= '0;
      nidx_q     <= '0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      sec_q      <= sec_d;
      hold_q     <= hold_d;
      tmo_q      <= tmo_d;
      nidx_q     <= nidx_d;
      rd_idx_q   <= rd_idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = active;
  assign done     = done_q;
  assign err      = err_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_idx   = rd_idx_q;
  assign sd_sec   = sec_q;
  assign sd_read  = (state_q == S_ISSUE);

endmodule

`default_nettype wire
